// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_decode
// Purpose  : RV32I ID/EX stage: decodes ALUCode, B-operand select, immediate
//            and write-enable into one registered stage with stall/flush.
// Options  : ALU_DEC_ILLEGAL_EN adds the registered IllegalInstr output.
// Revision : 1.0  initial release
// ============================================================================
module alu_ctrl_decode (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr,
   input  logic        InstrValid,
   input  logic        Stall,
   input  logic        Flush,
   output logic [3:0]  ALUCode,
   output logic        ALUSrcB,
   output logic [31:0] Imm,
   output logic        RegWrite,
`ifdef ALU_DEC_ILLEGAL_EN
   output logic        IllegalInstr,
`endif
   output logic        OutValid
);

   localparam logic [6:0] C_OPC_OP     = 7'b0110011;
   localparam logic [6:0] C_OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
   localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] C_OPC_STORE  = 7'b0100011;

   localparam logic [3:0] C_ALU_ADD  = 4'b0000;
   localparam logic [3:0] C_ALU_SUB  = 4'b0001;
   localparam logic [3:0] C_ALU_LUI  = 4'b0010;
   localparam logic [3:0] C_ALU_AND  = 4'b0011;
   localparam logic [3:0] C_ALU_XOR  = 4'b0100;
   localparam logic [3:0] C_ALU_OR   = 4'b0101;
   localparam logic [3:0] C_ALU_SLL  = 4'b0110;
   localparam logic [3:0] C_ALU_SRL  = 4'b0111;
   localparam logic [3:0] C_ALU_SRA  = 4'b1000;
   localparam logic [3:0] C_ALU_SLT  = 4'b1001;
   localparam logic [3:0] C_ALU_SLTU = 4'b1010;

   localparam logic [2:0] C_F3_ADD = 3'b000;
   localparam logic [2:0] C_F3_SLL = 3'b001;
   localparam logic [2:0] C_F3_SR  = 3'b101;

   localparam logic [6:0] C_F7_BASE = 7'b0000000;
   localparam logic [6:0] C_F7_ALT  = 7'b0100000;

   // Shared funct3 map; alt selects the sub/sra variants of 000/101.
   function automatic logic [3:0] f3_to_alu(input logic [2:0] f3, input logic alt);
      logic [3:0] code;
      case (f3)
         3'b000:  code = alt ? C_ALU_SUB : C_ALU_ADD;
         3'b001:  code = C_ALU_SLL;
         3'b010:  code = C_ALU_SLT;
         3'b011:  code = C_ALU_SLTU;
         3'b100:  code = C_ALU_XOR;
         3'b101:  code = alt ? C_ALU_SRA : C_ALU_SRL;
         3'b110:  code = C_ALU_OR;
         default: code = C_ALU_AND;
      endcase
      return code;
   endfunction

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        is_shift;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_u;
   logic [31:0] imm_sh;

   assign opcode   = Instr[6:0];
   assign funct3   = Instr[14:12];
   assign is_shift = (funct3 == C_F3_SLL) || (funct3 == C_F3_SR);
   assign imm_i    = {{20{Instr[31]}}, Instr[31:20]};
   assign imm_s    = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
   assign imm_u    = {Instr[31:12], 12'b0};
   assign imm_sh   = {27'b0, Instr[24:20]};

   logic [3:0]  dec_code;
   logic        dec_srcb;
   logic [31:0] dec_imm;
   logic        dec_rw;

`ifdef ALU_DEC_ILLEGAL_EN
   logic [6:0]  funct7;
   logic        dec_ill;
   logic        op_f7_ok;
   logic        imm_f7_ok;

   assign funct7 = Instr[31:25];
   assign op_f7_ok = (funct7 == C_F7_BASE) ||
                     ((funct7 == C_F7_ALT) && ((funct3 == C_F3_ADD) || (funct3 == C_F3_SR)));
   assign imm_f7_ok = !is_shift || (funct7 == C_F7_BASE) ||
                      ((funct3 == C_F3_SR) && (funct7 == C_F7_ALT));
`endif

   always_comb begin
      dec_code = C_ALU_ADD;
      dec_srcb = 1'b0;
      dec_imm  = 32'b0;
      dec_rw   = 1'b0;
`ifdef ALU_DEC_ILLEGAL_EN
      dec_ill  = 1'b0;
`endif
      case (opcode)
         C_OPC_OP: begin
            dec_code = f3_to_alu(funct3, Instr[30]);
            dec_rw   = 1'b1;
`ifdef ALU_DEC_ILLEGAL_EN
            dec_ill  = !op_f7_ok;
`endif
         end
         C_OPC_OP_IMM: begin
            // No subi exists, so bit 30 only matters for the right shift.
            dec_code = f3_to_alu(funct3, Instr[30] && (funct3 == C_F3_SR));
            dec_srcb = 1'b1;
            dec_imm  = is_shift ? imm_sh : imm_i;
            dec_rw   = 1'b1;
`ifdef ALU_DEC_ILLEGAL_EN
            dec_ill  = !imm_f7_ok;
`endif
         end
         C_OPC_LUI: begin
            dec_code = C_ALU_LUI;
            dec_srcb = 1'b1;
            dec_imm  = imm_u;
            dec_rw   = 1'b1;
         end
         C_OPC_LOAD: begin
            dec_srcb = 1'b1;
            dec_imm  = imm_i;
            dec_rw   = 1'b1;
         end
         C_OPC_STORE: begin
            dec_srcb = 1'b1;
            dec_imm  = imm_s;
         end
         default: begin
`ifdef ALU_DEC_ILLEGAL_EN
            dec_ill  = 1'b1;
`endif
         end
      endcase
`ifdef ALU_DEC_ILLEGAL_EN
      if (dec_ill) begin
         dec_rw = 1'b0;
      end
`endif
   end

   logic [3:0]  code_q,  code_d;
   logic        srcb_q,  srcb_d;
   logic [31:0] imm_q,   imm_d;
   logic        rw_q,    rw_d;
   logic        valid_q, valid_d;
`ifdef ALU_DEC_ILLEGAL_EN
   logic        ill_q,   ill_d;
`endif

   // Flush beats Stall; an unstalled empty slot also becomes a bubble.
   always_comb begin
      code_d  = code_q;
      srcb_d  = srcb_q;
      imm_d   = imm_q;
      rw_d    = rw_q;
      valid_d = valid_q;
`ifdef ALU_DEC_ILLEGAL_EN
      ill_d   = ill_q;
`endif
      if (Flush || (!Stall && !InstrValid)) begin
         code_d  = C_ALU_ADD;
         srcb_d  = 1'b0;
         imm_d   = 32'b0;
         rw_d    = 1'b0;
         valid_d = 1'b0;
`ifdef ALU_DEC_ILLEGAL_EN
         ill_d   = 1'b0;
`endif
      end else if (!Stall) begin
         code_d  = dec_code;
         srcb_d  = dec_srcb;
         imm_d   = dec_imm;
         rw_d    = dec_rw;
         valid_d = 1'b1;
`ifdef ALU_DEC_ILLEGAL_EN
         ill_d   = dec_ill;
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         code_q  <= C_ALU_ADD;
         srcb_q  <= 1'b0;
         imm_q   <= 32'b0;
         rw_q    <= 1'b0;
         valid_q <= 1'b0;
`ifdef ALU_DEC_ILLEGAL_EN
         ill_q   <= 1'b0;
`endif
      end else begin
         code_q  <= code_d;
         srcb_q  <= srcb_d;
         imm_q   <= imm_d;
         rw_q    <= rw_d;
         valid_q <= valid_d;
`ifdef ALU_DEC_ILLEGAL_EN
         ill_q   <= ill_d;
`endif
      end
   end

   assign ALUCode  = code_q;
   assign ALUSrcB  = srcb_q;
   assign Imm      = imm_q;
   assign RegWrite = rw_q;
   assign OutValid = valid_q;
`ifdef ALU_DEC_ILLEGAL_EN
   assign IllegalInstr = ill_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_ctrl_decode
// Purpose  : Directed plus randomized bench for alu_ctrl_decode against an
//            arithmetic reference model; honours ALU_DEC_ILLEGAL_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_ctrl_decode;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Instr;
   logic        InstrValid;
   logic        Stall;
   logic        Flush;
   logic [3:0]  ALUCode;
   logic        ALUSrcB;
   logic [31:0] Imm;
   logic        RegWrite;
   logic        OutValid;
   logic        IllegalInstr;

   alu_ctrl_decode dut (
      .clk        (clk),
      .reset      (reset),
      .Instr      (Instr),
      .InstrValid (InstrValid),
      .Stall      (Stall),
      .Flush      (Flush),
      .ALUCode    (ALUCode),
      .ALUSrcB    (ALUSrcB),
      .Imm        (Imm),
      .RegWrite   (RegWrite),
`ifdef ALU_DEC_ILLEGAL_EN
      .IllegalInstr (IllegalInstr),
`endif
      .OutValid   (OutValid)
   );

`ifndef ALU_DEC_ILLEGAL_EN
   assign IllegalInstr = 1'b0;
`endif

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  code;
      logic        srcb;
      logic [31:0] imm;
      logic        rw;
      logic        ov;
      logic        ill;
   } exp_t;

   int   n_total = 0;
   int   n_bad   = 0;
   int   alu_tab [8];
   exp_t mdl;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t bubble();
      exp_t e;
      e.code = 4'd0; e.srcb = 1'b0; e.imm = 32'd0; e.rw = 1'b0; e.ov = 1'b0; e.ill = 1'b0;
      return e;
   endfunction

   // Reference decode from the ISA rules using plain integer arithmetic.
   function automatic exp_t ref_decode(input logic [31:0] ins);
      exp_t               e;
      int                 op, f3, f7;
      logic signed [31:0] sx, t;
      e    = bubble();
      e.ov = 1'b1;
      op   = int'(ins & 32'h7F);
      f3   = int'((ins >> 12) & 32'h7);
      f7   = int'((ins >> 25) & 32'h7F);
      sx   = $signed(ins);
      if (op == 'h33) begin
         e.code = 4'(alu_tab[f3]);
         if (ins[30] && f3 == 0) e.code = 4'd1;
         if (ins[30] && f3 == 5) e.code = 4'd8;
         e.rw  = 1'b1;
         e.ill = !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
      end else if (op == 'h13) begin
         e.code = 4'(alu_tab[f3]);
         if (ins[30] && f3 == 5) e.code = 4'd8;
         e.srcb = 1'b1;
         e.rw   = 1'b1;
         if (f3 == 1 || f3 == 5) begin
            e.imm = (ins >> 20) & 32'h1F;
         end else begin
            t     = sx >>> 20;
            e.imm = t;
         end
         e.ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32);
      end else if (op == 'h37) begin
         e.code = 4'd2; e.srcb = 1'b1; e.imm = ins & 32'hFFFFF000; e.rw = 1'b1;
      end else if (op == 'h03) begin
         t      = sx >>> 20;
         e.srcb = 1'b1; e.imm = t; e.rw = 1'b1;
      end else if (op == 'h23) begin
         t      = sx >>> 25;
         e.srcb = 1'b1;
         e.imm  = (t << 5) | ((ins >> 7) & 32'h1F);
      end else begin
         e.ill = 1'b1;
      end
`ifdef ALU_DEC_ILLEGAL_EN
      if (e.ill) e.rw = 1'b0;
`else
      e.ill = 1'b0;
`endif
      return e;
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".ALUCode"},  32'(ALUCode),  32'(mdl.code));
      chk({tag, ".ALUSrcB"},  32'(ALUSrcB),  32'(mdl.srcb));
      chk({tag, ".Imm"},      Imm,           mdl.imm);
      chk({tag, ".RegWrite"}, 32'(RegWrite), 32'(mdl.rw));
      chk({tag, ".OutValid"}, 32'(OutValid), 32'(mdl.ov));
`ifdef ALU_DEC_ILLEGAL_EN
      chk({tag, ".Illegal"},  32'(IllegalInstr), 32'(mdl.ill));
`endif
   endtask

   // Drive one cycle of inputs, advance the model at the edge, check at negedge.
   task automatic step(input string tag, input logic [31:0] ins, input logic iv,
                       input logic st, input logic fl);
      Instr = ins; InstrValid = iv; Stall = st; Flush = fl;
      @(posedge clk);
      if (reset)         mdl = bubble();
      else if (fl)       mdl = bubble();
      else if (st)       mdl = mdl;
      else if (!iv)      mdl = bubble();
      else               mdl = ref_decode(ins);
      @(negedge clk);
      check_all(tag);
   endtask

   // Async reset pulse between edges; outputs must clear without a clock.
   task automatic async_reset(input string tag);
      #1 reset = 1'b1;
      #1;
      mdl = bubble();
      check_all(tag);
      #1 reset = 1'b0;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      int          sel, pick;
      r    = $urandom;
      sel  = int'($urandom_range(0, 7));
      pick = int'($urandom_range(0, 3));
      case (sel)
         0, 1: begin
            r[6:0] = 7'b0110011;
            if (pick < 3) r[31:25] = (pick == 0) ? 7'h20 : 7'h00;
         end
         2, 3: begin
            r[6:0] = 7'b0010011;
            if (pick < 3) r[31:25] = (pick == 0) ? 7'h20 : 7'h00;
         end
         4: r[6:0] = 7'b0110111;
         5: r[6:0] = 7'b0000011;
         6: r[6:0] = 7'b0100011;
         default: ;
      endcase
      return r;
   endfunction

   initial begin
      alu_tab = '{0, 6, 9, 10, 4, 7, 5, 3};
      mdl = bubble();
      reset = 1'b1; Instr = 32'h002081B3; InstrValid = 1'b1; Stall = 1'b0; Flush = 1'b0;
      @(negedge clk);
      check_all("reset_init");
      step("reset_hold", 32'h002081B3, 1'b1, 1'b0, 1'b0);
      reset = 1'b0;

      step("add0", 32'h002081B3, 1'b1, 1'b0, 1'b0);
      chk("add0_code", 32'(ALUCode), 32'h0);
      chk("add0_ov", 32'(OutValid), 32'h1);

      async_reset("async_rst");
      chk("async_rst_ov", 32'(OutValid), 32'h0);
      step("add1", 32'h002081B3, 1'b1, 1'b0, 1'b0);
      chk("add1_code", 32'(ALUCode), 32'h0);
      chk("add1_srcb", 32'(ALUSrcB), 32'h0);
      chk("add1_rw", 32'(RegWrite), 32'h1);
      chk("add1_ov", 32'(OutValid), 32'h1);

      step("sub", 32'h402081B3, 1'b1, 1'b0, 1'b0);
      chk("sub_code", 32'(ALUCode), 32'h1);
      step("addi", 32'hFFF00093, 1'b1, 1'b0, 1'b0);
      chk("addi_code", 32'(ALUCode), 32'h0);
      chk("addi_srcb", 32'(ALUSrcB), 32'h1);
      chk("addi_imm", Imm, 32'hFFFFFFFF);

      step("srai", 32'h40335293, 1'b1, 1'b0, 1'b0);
      chk("srai_code", 32'(ALUCode), 32'h8);
      chk("srai_imm", Imm, 32'h00000003);
      step("lui", 32'h123450B7, 1'b1, 1'b0, 1'b0);
      chk("lui_code", 32'(ALUCode), 32'h2);
      chk("lui_imm", Imm, 32'h12345000);

      step("st_add", 32'h002081B3, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step("stall", 32'h402081B3, 1'b1, 1'b1, 1'b0);
         chk("stall_code", 32'(ALUCode), 32'h0);
         chk("stall_ov", 32'(OutValid), 32'h1);
      end
      step("stall_rel", 32'h402081B3, 1'b1, 1'b0, 1'b0);
      chk("stall_rel_code", 32'(ALUCode), 32'h1);

      step("stall_flush", 32'h402081B3, 1'b1, 1'b1, 1'b1);
      chk("sf_ov", 32'(OutValid), 32'h0);
      chk("sf_rw", 32'(RegWrite), 32'h0);
      step("reload", 32'h402081B3, 1'b1, 1'b0, 1'b0);
      step("no_valid", 32'h402081B3, 1'b0, 1'b0, 1'b0);
      chk("nv_ov", 32'(OutValid), 32'h0);
      step("stall_bubble", 32'h002081B3, 1'b0, 1'b1, 1'b0);
      chk("stb_ov", 32'(OutValid), 32'h0);

      step("f7bad", 32'h022081B3, 1'b1, 1'b0, 1'b0);
      chk("f7bad_ov", 32'(OutValid), 32'h1);
`ifdef ALU_DEC_ILLEGAL_EN
      chk("f7bad_ill", 32'(IllegalInstr), 32'h1);
      chk("f7bad_rw", 32'(RegWrite), 32'h0);
`else
      chk("f7bad_code", 32'(ALUCode), 32'h0);
      chk("f7bad_rw", 32'(RegWrite), 32'h1);
`endif

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 59) == 0) async_reset("rnd_rst");
         step("rnd", rand_instr(), ($urandom_range(0, 9) != 0),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_ctrl_decode.md
# alu_ctrl_decode

- Registered decode stage that turns a 32-bit RV32I instruction into the 4-bit `ALUCode` and operand controls consumed by the ALU.
- Sits at the end of ID and drives the ID/EX boundary: one pipeline register with valid, stall and flush control.
- Produces `ALUCode` in the exact encoding the ALU decodes, plus the selected immediate and write-back enable.

## Interface
Parameters:
- none. Widths are fixed by RV32I.

Ports:
- `clk`  in  1  sole clock, rising-edge.
- `reset`  in  1  asynchronous, active-high; clears the stage register.
- `Instr`  in  32  instruction word from IF/ID.
- `InstrValid`  in  1  `Instr` holds a real instruction this cycle.
- `Stall`  in  1  hold all outputs at their current values.
- `Flush`  in  1  load a bubble.
- `ALUCode`  out  4  ALU operation select:
  - add=0000, sub=0001, lui=0010, and=0011, xor=0100, or=0101
  - sll=0110, srl=0111, sra=1000, slt=1001, sltu=1010
- `ALUSrcB`  out  1  1 = B operand is `Imm`; 0 = B operand is rs2.
- `Imm`  out  32  decoded immediate.
- `RegWrite`  out  1  instruction writes rd.
- `OutValid`  out  1  outputs describe a valid instruction.
- `IllegalInstr`  out  1  present only with `ALU_DEC_ILLEGAL_EN`.

## Operation
Decode is by opcode `Instr[6:0]`:
- OP (0110011):
  - funct3 selects add/sll/slt/sltu/xor/srl/or/and.
  - `Instr[30]`=1 turns funct3 000 into sub and funct3 101 into sra.
  - `ALUSrcB`=0, `Imm`=0, `RegWrite`=1.
- OP-IMM (0010011): same funct3 map, no sub form.
  - srai is funct3 101 with `Instr[30]`=1.
  - `ALUSrcB`=1, `RegWrite`=1.
  - `Imm`: sign-extended `Instr[31:20]`, except shifts, which use zero-extended shamt `Instr[24:20]`.
- LUI (0110111): `ALUCode`=lui, `ALUSrcB`=1, `Imm`={`Instr[31:12]`,12'b0}, `RegWrite`=1.
- LOAD (0000011): `ALUCode`=add, `ALUSrcB`=1, I-immediate, `RegWrite`=1.
- STORE (0100011): `ALUCode`=add, `ALUSrcB`=1, `RegWrite`=0.
  - Immediate is sign-extended {`Instr[31:25]`,`Instr[11:7]`}.
- Any other opcode: `ALUCode`=add, `ALUSrcB`=0, `Imm`=0, `RegWrite`=0, `OutValid` still 1.
- Bubble value: `ALUCode`=0, `ALUSrcB`=0, `Imm`=0, `RegWrite`=0, `OutValid`=0, `IllegalInstr`=0. This is also the reset value of every output.

## Timing
- Latency is 1 cycle: `Instr` sampled at edge N appears on outputs after edge N.
- Outputs come from flops only; there is no combinational path from inputs to outputs.
- Per-edge priority:
  - `reset` overrides everything. It forces the bubble immediately, independent of `clk`.
  - Then `Flush`: load the bubble. Flush wins when `Stall` is asserted in the same cycle.
  - Then `Stall`: hold all outputs, including `OutValid`.
  - Then `InstrValid`=0: load the bubble.
  - Otherwise: load the decode of `Instr`.
- Stall may last any number of cycles. The held instruction issues on the first edge after `Stall` drops.
- Reset deassertion mid-stream: the first edge after release loads normally under the priorities above.

## Configuration
`ALU_DEC_ILLEGAL_EN` defined:
- `IllegalInstr` exists. It is registered with the other outputs and sets to 1 for:
  - unsupported opcodes;
  - OP with funct7 other than 0000000, or 0100000 on funct3 000/101;
  - slli/srli/srai with a non-canonical funct7.
- Flagged instructions load with `RegWrite`=0 and `OutValid`=1.

`ALU_DEC_ILLEGAL_EN` undefined:
- No `IllegalInstr` port.
- funct7 is ignored except `Instr[30]`.
- Unsupported opcodes decode as above with no flag.

## Test plan
- Reset asserted mid-run -> all outputs 0 without a clock edge; after release, 0x002081B3 (add) -> next cycle `ALUCode`=0000, `ALUSrcB`=0, `RegWrite`=1, `OutValid`=1.
- 0x402081B3 (sub), then 0xFFF00093 (addi -1) -> `ALUCode`=0001, then `ALUCode`=0000 with `ALUSrcB`=1 and `Imm`=0xFFFFFFFF.
- 0x40335293 (srai x5,x6,3), then 0x123450B7 (lui 0x12345) -> `ALUCode`=1000 with `Imm`=0x00000003, then `ALUCode`=0010 with `Imm`=0x12345000.
- Add loaded, then sub presented with `Stall`=1 for 3 cycles -> add outputs held 3 cycles; sub appears 1 cycle after `Stall` drops.
- `Stall`=1 and `Flush`=1 together -> bubble loaded (`OutValid`=0, `RegWrite`=0); `InstrValid`=0 -> bubble.
- With `ALU_DEC_ILLEGAL_EN`: 0x022081B3 (funct7=0000001) -> `IllegalInstr`=1, `RegWrite`=0, `OutValid`=1. Without it: decodes as add with `RegWrite`=1.
